// File: rtl/mux4_2_if.sv
// Lane bundle between the 4-lane upstream source and the 2-lane re-serializer.
// The master side drives input lanes; the slave side (the re-serializer) drives ready and output lanes.
interface mux4_2_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic             valid_in0;
    logic             valid_in1;
    logic             valid_in2;
    logic             valid_in3;
    logic             ready_in;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic             valid_out0;
    logic             valid_out1;
    logic             sel_out;

    modport master (
        output in0, in1, in2, in3,
        output valid_in0, valid_in1, valid_in2, valid_in3,
        input  ready_in,
        input  out0, out1, valid_out0, valid_out1, sel_out
    );

    modport slave (
        input  in0, in1, in2, in3,
        input  valid_in0, valid_in1, valid_in2, valid_in3,
        output ready_in,
        output out0, out1, valid_out0, valid_out1, sel_out
    );
endinterface

// File: rtl/mux4_2.sv
// 4-lane to 2-lane byte re-serializer: lanes 0/1 leave one cycle after acceptance,
// lanes 2/3 are held and leave on the following cycle.
module mux4_2 #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    mux4_2_if.slave      bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HI   = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] out0_r, out0_nxt_s;
    logic [WIDTH-1:0] out1_r, out1_nxt_s;
    logic             valid_out0_r, valid_out0_nxt_s;
    logic             valid_out1_r, valid_out1_nxt_s;
    logic             sel_out_r, sel_out_nxt_s;
    logic [WIDTH-1:0] hd2_r, hd2_nxt_s;
    logic [WIDTH-1:0] hd3_r, hd3_nxt_s;
    logic             hv2_r, hv2_nxt_s;
    logic             hv3_r, hv3_nxt_s;
    logic             any_valid_s;

    assign any_valid_s    = bus.valid_in0 | bus.valid_in1 | bus.valid_in2 | bus.valid_in3;
    // Ready depends on state only so upstream never sees a combinational loop through us.
    assign bus.ready_in   = (state_r == IDLE);
    assign bus.out0       = out0_r;
    assign bus.out1       = out1_r;
    assign bus.valid_out0 = valid_out0_r;
    assign bus.valid_out1 = valid_out1_r;
    assign bus.sel_out    = sel_out_r;

    // Next-state and next-output decode.
    always_comb begin
        state_nxt_s      = state_r;
        out0_nxt_s       = out0_r;
        out1_nxt_s       = out1_r;
        valid_out0_nxt_s = valid_out0_r;
        valid_out1_nxt_s = valid_out1_r;
        sel_out_nxt_s    = sel_out_r;
        hd2_nxt_s        = hd2_r;
        hd3_nxt_s        = hd3_r;
        hv2_nxt_s        = hv2_r;
        hv3_nxt_s        = hv3_r;
        case (state_r)
            IDLE: begin
                if (any_valid_s) begin
                    out0_nxt_s       = bus.valid_in0 ? bus.in0 : ZERO_W;
                    valid_out0_nxt_s = bus.valid_in0;
                    out1_nxt_s       = bus.valid_in1 ? bus.in1 : ZERO_W;
                    valid_out1_nxt_s = bus.valid_in1;
                    hd2_nxt_s        = bus.in2;
                    hv2_nxt_s        = bus.valid_in2;
                    hd3_nxt_s        = bus.in3;
                    hv3_nxt_s        = bus.valid_in3;
                    sel_out_nxt_s    = 1'b0;
                    state_nxt_s      = HI;
                end else begin
                    out0_nxt_s       = ZERO_W;
                    out1_nxt_s       = ZERO_W;
                    valid_out0_nxt_s = 1'b0;
                    valid_out1_nxt_s = 1'b0;
                    sel_out_nxt_s    = 1'b0;
                    state_nxt_s      = IDLE;
                end
            end
            HI: begin
                // Inputs are ignored here; the held upper lanes always take this slot.
                out0_nxt_s       = hv2_r ? hd2_r : ZERO_W;
                valid_out0_nxt_s = hv2_r;
                out1_nxt_s       = hv3_r ? hd3_r : ZERO_W;
                valid_out1_nxt_s = hv3_r;
                sel_out_nxt_s    = 1'b1;
                hv2_nxt_s        = 1'b0;
                hv3_nxt_s        = 1'b0;
                state_nxt_s      = IDLE;
            end
            default: begin
                out0_nxt_s       = ZERO_W;
                out1_nxt_s       = ZERO_W;
                valid_out0_nxt_s = 1'b0;
                valid_out1_nxt_s = 1'b0;
                sel_out_nxt_s    = 1'b0;
                hv2_nxt_s        = 1'b0;
                hv3_nxt_s        = 1'b0;
                state_nxt_s      = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output and hold registers; a reset discards any pending upper lanes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out0_r       <= ZERO_W;
            out1_r       <= ZERO_W;
            valid_out0_r <= 1'b0;
            valid_out1_r <= 1'b0;
            sel_out_r    <= 1'b0;
            hd2_r        <= ZERO_W;
            hd3_r        <= ZERO_W;
            hv2_r        <= 1'b0;
            hv3_r        <= 1'b0;
        end else begin
            out0_r       <= out0_nxt_s;
            out1_r       <= out1_nxt_s;
            valid_out0_r <= valid_out0_nxt_s;
            valid_out1_r <= valid_out1_nxt_s;
            sel_out_r    <= sel_out_nxt_s;
            hd2_r        <= hd2_nxt_s;
            hd3_r        <= hd3_nxt_s;
            hv2_r        <= hv2_nxt_s;
            hv3_r        <= hv3_nxt_s;
        end
    end
endmodule
